// File: rtl/seq_memory_if.sv
// Request/response bundle between the game controller and the sequence memory.
// The controller side is the master; the memory itself is the slave.
interface seq_memory_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 4
);
  logic                  clr;
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  r_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic [ADDR_WIDTH:0]   len;
  logic                  full;
  logic                  overflow;
  logic                  busy;

  modport master (
    output clr, w_en, w_addr, w_data, push, push_data, r_en, r_addr,
    input  r_data, r_valid, len, full, overflow, busy
  );

  modport slave (
    input  clr, w_en, w_addr, w_data, push, push_data, r_en, r_addr,
    output r_data, r_valid, len, full, overflow, busy
  );
endinterface

// File: rtl/seq_memory.sv
// Sequence memory for the Simon datapath: a single-write-port store that is
// cleared one entry per cycle (so it maps onto block/distributed RAM with no
// parallel reset), an append port that tracks sequence length, and a
// registered read port with optional forwarding of a same-cycle write.
module seq_memory #(
  parameter int N_ELEMENTS = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 4,
  parameter bit BYPASS     = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  seq_memory_if.slave  bus
);

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam logic [ADDR_WIDTH:0]   N_LEN     = (ADDR_WIDTH+1)'(N_ELEMENTS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_ELEMENTS - 1);

  logic [DATA_WIDTH-1:0] mem [N_ELEMENTS];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic                  r_valid_q, r_valid_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  full;
  logic                  w_in_range;
  logic                  r_in_range;

  assign full       = (len_q == N_LEN);
  assign w_in_range = ({1'b0, bus.w_addr} < N_LEN);
  assign r_in_range = ({1'b0, bus.r_addr} < N_LEN);

  // Next-state logic: the single memory write port is shared by the clear
  // sweep, the append port and the random-access port (append beats w_en),
  // and the read result is chosen from RAM or the write being performed.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    len_d      = len_q;
    overflow_d = overflow_q;
    r_data_d   = r_data_q;
    r_valid_d  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = clr_addr_q;
    mem_wdata  = '0;

    if (rst) begin
      state_d    = CLEAR;
      clr_addr_d = '0;
      len_d      = '0;
      overflow_d = 1'b0;
      r_data_d   = '0;
    end else begin
      case (state_q)
        CLEAR: begin
          mem_we     = 1'b1;
          mem_waddr  = clr_addr_q;
          clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
          if (clr_addr_q == LAST_ADDR) begin
            state_d    = IDLE;
            clr_addr_d = '0;
          end
        end
        IDLE: begin
          if (bus.clr) begin
            state_d    = CLEAR;
            clr_addr_d = '0;
            len_d      = '0;
            overflow_d = 1'b0;
          end else begin
            if (bus.push) begin
              if (full) begin
                overflow_d = 1'b1;
              end else begin
                mem_we    = 1'b1;
                mem_waddr = len_q[ADDR_WIDTH-1:0];
                mem_wdata = bus.push_data;
                len_d     = len_q + (ADDR_WIDTH+1)'(1);
              end
            end else if (bus.w_en && w_in_range) begin
              mem_we    = 1'b1;
              mem_waddr = bus.w_addr;
              mem_wdata = bus.w_data;
            end
            if (bus.r_en) begin
              r_valid_d = 1'b1;
              if (!r_in_range)
                r_data_d = '0;
              else if (BYPASS && mem_we && (mem_waddr == bus.r_addr))
                r_data_d = mem_wdata;
              else
                r_data_d = mem[bus.r_addr];
            end
          end
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  // Control and read-port registers; all reset behaviour lives in the _d logic.
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    clr_addr_q <= clr_addr_d;
    len_q      <= len_d;
    overflow_q <= overflow_d;
    r_data_q   <= r_data_d;
    r_valid_q  <= r_valid_d;
  end

  // Storage array with one write port and no reset so it infers as RAM.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  assign bus.r_data   = r_data_q;
  assign bus.r_valid  = r_valid_q;
  assign bus.len      = len_q;
  assign bus.full     = full;
  assign bus.overflow = overflow_q;
  assign bus.busy     = (state_q == CLEAR);

endmodule

// File: doc/seq_memory.md
# seq_memory

Parametrised single-clock sequence memory for the Simon datapath, replacing the flat 64x4 store. Adds a one-entry-per-cycle clear engine (RAM-inferable, no parallel reset), an append port that tracks the stored sequence length, and a registered read port with optional write-to-read forwarding. Sits between the game controller (which appends colours and replays them) and the display/compare logic.

## Interface
- N_ELEMENTS, 64, number of entries (any value 2..2^ADDR_WIDTH)
- ADDR_WIDTH, 6, address width
- DATA_WIDTH, 4, entry width
- BYPASS, 1, 1: same-cycle write to the read address forwards new data; 0: read returns old data

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high; starts a clear sweep
- clr  in  1  start clear sweep (pulse, honoured only in IDLE)
- w_en  in  1  random-access write enable
- w_addr  in  ADDR_WIDTH  write address
- w_data  in  DATA_WIDTH  write data
- push  in  1  append push_data at address len
- push_data  in  DATA_WIDTH  append data
- r_en  in  1  read request
- r_addr  in  ADDR_WIDTH  read address
- r_data  out  DATA_WIDTH  registered read data
- r_valid  out  1  r_data updated this cycle (1-cycle pulse per accepted read)
- len  out  ADDR_WIDTH+1  entries appended since last clear, 0..N_ELEMENTS
- full  out  1  len == N_ELEMENTS
- overflow  out  1  sticky: push attempted while full
- busy  out  1  clear sweep in progress; all requests ignored

## Operation
- States: CLEAR, IDLE. rst forces CLEAR with clr_addr=0 regardless of current state (reset mid-sweep restarts at 0).
- CLEAR: each cycle with rst low writes mem[clr_addr]<=0, clr_addr++; after writing N_ELEMENTS-1 go to IDLE. While rst held, clr_addr stays 0.
- IDLE + clr: go to CLEAR, clr_addr<=0, len<=0, overflow<=0. Same-cycle w_en/push/r_en dropped.
- clr in CLEAR: ignored (sweep not restarted).
- In CLEAR, w_en, push, r_en ignored: no memory change, r_valid=0, r_data holds, len unchanged.
- push (IDLE, !full): mem[len]<=push_data, len++. push while full: no write, len holds, overflow<=1.
- w_en (IDLE): mem[w_addr]<=w_data; w_addr>=N_ELEMENTS ignored. w_en does not change len.
- push and w_en same cycle: push wins; w_en dropped (even if push itself dropped for full).
- r_en (IDLE): r_data<=mem[r_addr] next edge, r_valid<=1. r_addr>=N_ELEMENTS returns 0. No r_en: r_valid<=0, r_data holds.
- Forwarding: accepted write (push or w_en) and r_en same cycle, same address: BYPASS=1 returns written data; BYPASS=0 returns prior contents.

## Timing
- Reset values (edge with rst=1): state=CLEAR, busy=1, len=0, full=0, overflow=0, r_data=0, r_valid=0.
- busy stays 1 for exactly N_ELEMENTS cycles after the last rst-high edge (or after the clr edge), then 0.
- Read latency 1 cycle: r_en sampled at edge k, r_data/r_valid valid after edge k; back-to-back reads every cycle.
- Write visible to a read issued the following cycle (both BYPASS modes).
- len/full/overflow registered; update on the edge that accepts the push/clr.
- Throughput: one push or write plus one read per cycle.

## Test plan
- Reset then sweep: rst 1 cycle, N_ELEMENTS=64 -> busy=1 for 64 cycles, then 0; reads of addresses 0,31,63 return 0 with r_valid pulses.
- Append to full: 64 pushes of i%16 -> len 1..64, full=1 at 64; 65th push -> len=64, overflow=1, mem[63]=15 unchanged.
- Priority/forwarding: push 0xA to len=5 with w_en addr 5 data 0x3 and r_en addr 5 -> mem[5]=0xA; r_data=0xA (BYPASS=1) or previous value (BYPASS=0).
- Busy blocking: clr, then w_en addr 2 data 0xF and r_en during sweep -> mem[2]=0 after sweep, r_valid stays 0, r_data holds.
- Reset mid-sweep: rst at sweep cycle 20 -> busy remains 1 for a further 64 cycles from rst release; len=0.
- Non-power-of-two: N_ELEMENTS=40 -> sweep 40 cycles, full at len=40, r_addr 45 returns 0, w_addr 45 ignored.
